// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit operands through one shared
// 4-bit ripple slice. It processes one nibble per clock, LSB first, with
// valid/ready handshakes on both the request side and the result side.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned SLICES = WIDTH / 4;
    localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);

    // Only whole nibbles are supported, and there must be at least one.
    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             ripple_c;

    // Shared 4-bit ripple slice working on the nibble selected by idx.
    always_comb begin
        nib_a     = a_q[{idx_q, 2'b00} +: 4];
        nib_b     = b_q[{idx_q, 2'b00} +: 4];
        slice_sum = 4'h0;
        ripple_c  = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = nib_a[i] ^ nib_b[i] ^ ripple_c;
            ripple_c     = (nib_a[i] & nib_b[i]) | (ripple_c & (nib_a[i] ^ nib_b[i]));
        end
        slice_cout = ripple_c;
    end

    // Control FSM and datapath registers; the handshake outputs are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in0;
                        b_q        <= in1;
                        carry_q    <= cin;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= slice_sum;
                    carry_q                    <= slice_cout;
                    if (idx_q == IDX_LAST) begin
                        cout_q      <= slice_cout;
                        idx_q       <= '0;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int nvec;
    int nerr;
    int lat;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one accept edge, then count cycles until out_valid (bounded).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
        in0      = a;
        in1      = b;
        cin      = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Check a result in DONE and let the handshake (out_ready assumed 1) complete.
    task automatic finish_op(input string tag, input logic [15:0] es, input logic ec);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rdy_in_done"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_ov_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in0       = '0;
        in1       = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);

        issue(16'h1234, 16'h4321, 1'b0);
        finish_op("basic", 16'h5555, 1'b0);

        issue(16'hFFFF, 16'h0001, 1'b0);
        finish_op("ripple1", 16'h0000, 1'b1);

        issue(16'hFFFF, 16'h0000, 1'b1);
        finish_op("ripple_cin", 16'h0000, 1'b1);

        issue(16'h8000, 16'h8000, 1'b0);
        finish_op("msb", 16'h0000, 1'b1);

        // Backpressure: hold the result for 3 cycles, ignore a request pulse.
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0F0F, 1'b0);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int k = 0; k < 3; k++) begin
            in_valid = (k == 1);
            in0      = 16'h1111;
            in1      = 16'h2222;
            step();
            chk("bp_hold_sum", 32'(sum), 32'h100E);
            chk("bp_hold_cout", 32'(cout), 32'd0);
            chk("bp_hold_ov", 32'(out_valid), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_rdy_after", 32'(in_ready), 32'd1);
        chk("bp_busy_after", 32'(busy), 32'd0);
        step();
        chk("bp_still_idle", 32'(busy), 32'd0);

        // Operands change during RUN and must not affect the result.
        in0      = 16'hAAAA;
        in1      = 16'h5555;
        cin      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in0      = 16'hFFFF;
        in1      = 16'hFFFF;
        cin      = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        finish_op("stable", 16'h0000, 1'b1);

        // Reset while RUN is at idx=2.
        in0      = 16'h0F0F;
        in1      = 16'h0101;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rdy", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(sum), 32'h0);
        chk("midrst_cout", 32'(cout), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("midrst_no_ov", 32'(out_valid), 32'd0);
            step();
        end

        issue(16'h0001, 16'h0001, 1'b0);
        finish_op("post_rst", 16'h0002, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
